pin_transmitter: RTL and testbench
==================================

# pin_transmitter

Access-code transmitter for the parking-gate controller. On a request it drives the gate's presence line `A` and serial code line `B` with a stored N-bit code, MSB first. It then waits for the gate to raise its arm (`aguja`) and reports grant or denial. With retry compiled in, a timed-out attempt is repeated up to a fixed count. The block sits at the vehicle or keypad end, directly facing the gate controller's `A`/`B` inputs.

## Interface
- `PIN_W`, 5: code length in bits (≥1).
- `BIT_CYCLES`, 1: clocks each code bit is held on `B` (≥1).
- `TIMEOUT`, 15: clocks to wait for `aguja` after the last bit (≥1).
- `MAX_TRIES`, 3: total attempts when retry is enabled (≥1).

- `clock` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-low; sampled on `clock` rising edge.
- `start` in 1: request; sampled only in IDLE.
- `pin` in PIN_W: code; captured on the accepted `start`.
- `aguja` in 1: gate arm status from the controller; 1 = raised.
- `A` out 1: vehicle/presence line to the gate.
- `B` out 1: serial code bit to the gate.
- `busy` out 1: high in every state except IDLE.
- `granted` out 1: one-cycle pulse when the gate opens.
- `denied` out 1: one-cycle pulse when all attempts time out.

## Operation
- All outputs are registered.
- Reset values: `A`=0, `B`=0, `busy`=0, `granted`=0, `denied`=0; state IDLE; all counters 0.
- **IDLE**
  - `A`=0, `B`=0.
  - On `start`=1: capture `pin` into `pin_q`; set `bit_idx`=PIN_W-1, `bit_cnt`=0, `try`=0; go to SEND.
- **SEND**
  - `A`=1, `B`=`pin_q[bit_idx]`.
  - `bit_cnt` counts 0..BIT_CYCLES-1.
  - At terminal count with `bit_idx`=0: go to WAIT and clear `timer`.
  - At terminal count otherwise: decrement `bit_idx` and clear `bit_cnt`.
- **WAIT**
  - `A`=1, `B`=0.
  - `aguja`=1: go to PASS; `granted`=1 for that one cycle.
  - Otherwise `timer` increments.
  - At `timer`=TIMEOUT-1: go to GAP if a retry remains, else go to FAIL.
- **GAP** (retry only)
  - `A`=0, `B`=0 for exactly one cycle, so the gate FSM returns to its initial state.
  - Increment `try`, reload `bit_idx`/`bit_cnt`, go to SEND.
- **PASS**
  - `A`=1, `B`=0 while the vehicle passes.
  - Return to IDLE when `aguja`=0.
- **FAIL**
  - Single cycle: `A`=0, `denied`=1; then IDLE.
- Boundaries:
  - `start` outside IDLE is ignored.
  - `pin` changes after capture have no effect.
  - `aguja` is ignored in SEND and GAP.
  - `aguja`=1 on the same edge `timer` reaches terminal count: grant wins.
  - `reset`=0 in any state returns to IDLE on that edge with reset values.
- Widths:
  - `bit_idx` is clog2(PIN_W) bits, min 1.
  - `bit_cnt` is clog2(BIT_CYCLES) bits.
  - `timer` is clog2(TIMEOUT) bits.
  - `try` is clog2(MAX_TRIES) bits.
  - No counter wraps; each is cleared at its terminal count.

## Timing
- `start` accepted at edge k: `A`=1 and `B`=MSB visible from edge k+1.
- Each bit lasts BIT_CYCLES cycles; the full code takes PIN_W·BIT_CYCLES cycles.
- Maximum WAIT is TIMEOUT cycles.
- `aguja` rising, sampled at edge m: `granted` is high for the cycle after edge m.
- `granted` and `denied` never assert in the same cycle; each is exactly one cycle wide.
- Worst case to `denied` with retry: MAX_TRIES·(PIN_W·BIT_CYCLES + TIMEOUT) + (MAX_TRIES-1) + 1 cycles after acceptance.

## Configuration
- `PIN_TX_RETRY_EN` defined:
  - GAP state and `try` counter are present.
  - Up to MAX_TRIES attempts.
- `PIN_TX_RETRY_EN` undefined:
  - GAP and `try` are removed; MAX_TRIES is unused.
  - WAIT timeout goes directly to FAIL.

## Structure
- Shared package `gate_pkg`:
  - state enum (IDLE, SEND, WAIT, GAP, PASS, FAIL).
  - Default code constant `GATE_PIN_DEFAULT` = 5'b10100, matching the gate controller's sequence.
  - Default TIMEOUT constant.
- One sub-module, `tick_counter`: parameterised modulus, clear, enable, and a terminal-count output. It is instantiated for the bit timer and the timeout timer.

## Test plan
- Nominal open:
  - Stimulus: PIN_W=5, BIT_CYCLES=1, `pin`=5'b10100, `start` pulse, `aguja` raised on WAIT cycle 3, dropped 4 cycles later.
  - Response: `B` = 1,0,1,0,0 on cycles 1-5 with `A`=1 throughout; one `granted` pulse; `A`=1 until `aguja` drops; then IDLE.
- Bit stretching:
  - Stimulus: BIT_CYCLES=3.
  - Response: each bit is held exactly 3 cycles; total SEND is 15 cycles.
- Retry then deny:
  - Stimulus: retry enabled, `aguja` held 0, TIMEOUT=4, MAX_TRIES=3.
  - Response: three SEND bursts, each separated by one cycle of `A`=0; one `denied` pulse; `busy` falls the cycle after.
- Retry compiled out:
  - Stimulus: `PIN_TX_RETRY_EN` undefined, same stimulus as the previous test.
  - Response: one SEND burst, then `denied` after 4 WAIT cycles.
- Ignored requests and conflicts:
  - Stimulus: `start` and a new `pin` asserted mid-SEND; `aguja`=1 during SEND.
  - Response: the transmitted code is unchanged; `aguja` has no effect until WAIT.
  - Stimulus: `aguja` rises on the terminal timeout cycle.
  - Response: `granted`, not GAP/FAIL.
- Reset mid-operation:
  - Stimulus: `reset`=0 at bit 3 of SEND.
  - Response: on the next edge `A`=`B`=`busy`=0; a new `start` restarts from the MSB.

Source files
------------

// File: rtl/gate_pkg.sv
// Shared definitions for the parking-gate access-code link.
// Holds the transmitter state encoding, the default gate code, the default
// arm timeout and a counter-width helper used by every counter in the block.
package gate_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEND = 3'd1,
        WAIT = 3'd2,
        GAP  = 3'd3,
        PASS = 3'd4,
        FAIL = 3'd5
    } gate_state_t;

    // Code sequence the gate controller expects by default.
    localparam logic [4:0] GATE_PIN_DEFAULT = 5'b10100;

    // Clocks to wait for the arm to rise after the last code bit.
    localparam int GATE_TIMEOUT_DEFAULT = 15;

    // Width of a counter that counts 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_counter.sv
// Modulo-MOD tick counter with synchronous clear and enable.
// o_tc is high while the count sits at MOD-1; an enabled count at terminal
// value returns to zero on the next edge, so the counter never wraps past MOD.
module tick_counter
    import gate_pkg::*;
#(
    parameter int MOD = 1
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int CW = cnt_width(MOD);

    logic [CW-1:0] r_count;

    assign o_tc = (r_count == CW'(MOD - 1));

    // Count enabled cycles, restarting at zero on clear or at terminal count.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_count <= {CW{1'b0}};
        end else if (i_clr) begin
            r_count <= {CW{1'b0}};
        end else if (i_en) begin
            if (o_tc) begin
                r_count <= {CW{1'b0}};
            end else begin
                r_count <= r_count + CW'(1);
            end
        end else begin
            r_count <= r_count;
        end
    end

endmodule

// File: rtl/pin_transmitter.sv
// Access-code transmitter facing the parking-gate controller.
// On a request the captured code is shifted out MSB first on B while A is
// held high, then the block waits for the gate arm (aguja) and pulses
// granted or denied. Optional build macro PIN_TX_RETRY_EN adds a one-cycle
// A=0 gap and re-sends the code after a timeout, up to MAX_TRIES attempts.
// All outputs are registered from the next-state decode, so they change on
// the same edge as the state they describe.
module pin_transmitter
    import gate_pkg::*;
#(
    parameter int PIN_W      = 5,
    parameter int BIT_CYCLES = 1,
    parameter int TIMEOUT    = GATE_TIMEOUT_DEFAULT,
    parameter int MAX_TRIES  = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [PIN_W-1:0] pin,
    input  logic             aguja,
    output logic             A,
    output logic             B,
    output logic             busy,
    output logic             granted,
    output logic             denied
);

    localparam int IW = cnt_width(PIN_W);

    gate_state_t      r_state;
    gate_state_t      w_state_next;
    logic [PIN_W-1:0] r_pin_q;
    logic [PIN_W-1:0] w_pin_next;
    logic [IW-1:0]    r_bit_idx;
    logic [IW-1:0]    w_bit_idx_next;

    logic w_bit_en;
    logic w_bit_clr;
    logic w_bit_tc;
    logic w_tmo_en;
    logic w_tmo_clr;
    logic w_tmo_tc;
    logic w_retry_left;

    logic r_a;
    logic r_b;
    logic r_busy;
    logic r_granted;
    logic r_denied;
    logic w_a_next;
    logic w_b_next;
    logic w_busy_next;
    logic w_granted_next;
    logic w_denied_next;

`ifdef PIN_TX_RETRY_EN
    localparam int TW = cnt_width(MAX_TRIES);

    logic [TW-1:0] r_try;
    logic [TW-1:0] w_try_next;

    assign w_retry_left = (r_try < TW'(MAX_TRIES - 1));

    // Attempt counter: cleared on a new request, bumped in each gap.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_try <= {TW{1'b0}};
        end else begin
            r_try <= w_try_next;
        end
    end
`else
    // Without retry a timeout always ends the request.
    assign w_retry_left = (MAX_TRIES > 0) & 1'b0;
`endif

    // Per-bit hold timer; runs only while sending.
    tick_counter #(
        .MOD (BIT_CYCLES)
    ) u_bit_timer (
        .i_clock (clock),
        .i_reset (reset),
        .i_clr   (w_bit_clr),
        .i_en    (w_bit_en),
        .o_tc    (w_bit_tc)
    );

    // Arm timeout timer; runs only while waiting for the gate.
    tick_counter #(
        .MOD (TIMEOUT)
    ) u_tmo_timer (
        .i_clock (clock),
        .i_reset (reset),
        .i_clr   (w_tmo_clr),
        .i_en    (w_tmo_en),
        .o_tc    (w_tmo_tc)
    );

    // Next-state, code capture and bit-index sequencing.
    always_comb begin
        w_state_next   = r_state;
        w_pin_next     = r_pin_q;
        w_bit_idx_next = r_bit_idx;
        w_bit_en       = 1'b0;
        w_bit_clr      = 1'b1;
        w_tmo_en       = 1'b0;
        w_tmo_clr      = 1'b1;
`ifdef PIN_TX_RETRY_EN
        w_try_next     = r_try;
`endif
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next   = SEND;
                    w_pin_next     = pin;
                    w_bit_idx_next = IW'(PIN_W - 1);
`ifdef PIN_TX_RETRY_EN
                    w_try_next     = {TW{1'b0}};
`endif
                end else begin
                    w_state_next = IDLE;
                end
            end
            SEND: begin
                w_bit_en  = 1'b1;
                w_bit_clr = 1'b0;
                if (w_bit_tc) begin
                    if (r_bit_idx == {IW{1'b0}}) begin
                        w_state_next = WAIT;
                    end else begin
                        w_bit_idx_next = r_bit_idx - IW'(1);
                    end
                end else begin
                    w_state_next = SEND;
                end
            end
            WAIT: begin
                w_tmo_en  = 1'b1;
                w_tmo_clr = 1'b0;
                // A grant on the terminal timeout cycle takes priority.
                if (aguja) begin
                    w_state_next = PASS;
                end else if (w_tmo_tc) begin
                    w_state_next = w_retry_left ? GAP : FAIL;
                end else begin
                    w_state_next = WAIT;
                end
            end
`ifdef PIN_TX_RETRY_EN
            GAP: begin
                w_state_next   = SEND;
                w_bit_idx_next = IW'(PIN_W - 1);
                w_try_next     = r_try + TW'(1);
            end
`endif
            PASS: begin
                if (!aguja) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = PASS;
                end
            end
            FAIL: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Output decode from the state being entered, so lines follow the state.
    always_comb begin
        w_a_next       = 1'b0;
        w_b_next       = 1'b0;
        w_busy_next    = 1'b1;
        w_granted_next = (r_state == WAIT) && (w_state_next == PASS);
        w_denied_next  = 1'b0;
        case (w_state_next)
            IDLE: begin
                w_busy_next = 1'b0;
            end
            SEND: begin
                w_a_next = 1'b1;
                w_b_next = w_pin_next[w_bit_idx_next];
            end
            WAIT: begin
                w_a_next = 1'b1;
            end
            GAP: begin
                w_a_next = 1'b0;
            end
            PASS: begin
                w_a_next = 1'b1;
            end
            FAIL: begin
                w_denied_next = 1'b1;
            end
            default: begin
                w_busy_next = 1'b0;
            end
        endcase
    end

    // State, captured code, bit index and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_pin_q   <= {PIN_W{1'b0}};
            r_bit_idx <= {IW{1'b0}};
            r_a       <= 1'b0;
            r_b       <= 1'b0;
            r_busy    <= 1'b0;
            r_granted <= 1'b0;
            r_denied  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pin_q   <= w_pin_next;
            r_bit_idx <= w_bit_idx_next;
            r_a       <= w_a_next;
            r_b       <= w_b_next;
            r_busy    <= w_busy_next;
            r_granted <= w_granted_next;
            r_denied  <= w_denied_next;
        end
    end

    assign A       = r_a;
    assign B       = r_b;
    assign busy    = r_busy;
    assign granted = r_granted;
    assign denied  = r_denied;

endmodule

// File: tb/tb_pin_transmitter.sv
// Scoreboard bench for pin_transmitter. Two instances: one with one-cycle
// bits and a short timeout, one with three-cycle bits and the default
// timeout. Stimulus tasks push the expected {A,B,granted,denied} for every
// busy cycle; per-instance monitors pop and compare whenever busy is high
// and require all-quiet lines whenever it is low.
module tb_pin_transmitter;

    localparam int BC1 = 1;
    localparam int TO1 = 4;
    localparam int BC3 = 3;
    localparam int TO3 = 15;
`ifdef PIN_TX_RETRY_EN
    localparam int TRIES = 3;
`else
    localparam int TRIES = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start1 = 1'b0;
    logic       start3 = 1'b0;
    logic       aguja1 = 1'b0;
    logic       aguja3 = 1'b0;
    logic [4:0] pin = 5'd0;
    logic       a1, b1, busy1, g1, d1;
    logic       a3, b3, busy3, g3, d3;

    logic [3:0] q1[$];
    logic [3:0] q3[$];
    int         n_cmp = 0;
    int         n_err = 0;
    bit         mon_on = 1'b0;

    always #5 clk = ~clk;

    pin_transmitter #(
        .PIN_W(5), .BIT_CYCLES(BC1), .TIMEOUT(TO1), .MAX_TRIES(3)
    ) u_dut1 (
        .clock(clk), .reset(rst_n), .start(start1), .pin(pin), .aguja(aguja1),
        .A(a1), .B(b1), .busy(busy1), .granted(g1), .denied(d1)
    );

    pin_transmitter #(
        .PIN_W(5), .BIT_CYCLES(BC3), .TIMEOUT(TO3), .MAX_TRIES(3)
    ) u_dut3 (
        .clock(clk), .reset(rst_n), .start(start3), .pin(pin), .aguja(aguja3),
        .A(a3), .B(b3), .busy(busy3), .granted(g3), .denied(d3)
    );

    task automatic cmp(input string nm, input logic [4:0] act, input logic [4:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b (busy,A,B,granted,denied) t=%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor for instance 1.
    always @(negedge clk) begin
        if (mon_on) begin
            if (busy1) begin
                if (q1.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL dut1_unexpected_busy: got %b%b%b%b with empty queue t=%0t", a1, b1, g1, d1, $time);
                end else begin
                    cmp("dut1_cycle", {busy1, a1, b1, g1, d1}, {1'b1, q1.pop_front()});
                end
            end else begin
                cmp("dut1_idle", {busy1, a1, b1, g1, d1}, 5'b00000);
            end
        end
    end

    // Monitor for instance 3.
    always @(negedge clk) begin
        if (mon_on) begin
            if (busy3) begin
                if (q3.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL dut3_unexpected_busy: got %b%b%b%b with empty queue t=%0t", a3, b3, g3, d3, $time);
                end else begin
                    cmp("dut3_cycle", {busy3, a3, b3, g3, d3}, {1'b1, q3.pop_front()});
                end
            end else begin
                cmp("dut3_idle", {busy3, a3, b3, g3, d3}, 5'b00000);
            end
        end
    end

    task automatic push(input int sel, input logic [3:0] v);
        if (sel == 1) q1.push_back(v);
        else          q3.push_back(v);
    endtask

    task automatic drive(input int sel, input logic st, input logic ag);
        if (sel == 1) begin
            start1 = st;
            aguja1 = ag;
        end else begin
            start3 = st;
            aguja3 = ag;
        end
    endtask

    // One request: agu_w = WAIT cycle on which the arm rises (0 = never),
    // agu_hold = cycles it stays up. perturb = new start/pin and a stray
    // arm pulse on SEND cycles 2-3.
    task automatic run_txn(input string nm, input int sel, input logic [4:0] p,
                           input int bc, input int to, input int agu_w,
                           input int agu_hold, input int tries, input bit perturb);
        int  s;
        int  total;
        logic ag;
        logic st;
        s = 5 * bc;
        total = 0;
        for (int t = 0; t < tries; t++) begin
            for (int i = 4; i >= 0; i--) begin
                for (int k = 0; k < bc; k++) begin
                    push(sel, {1'b1, p[i], 2'b00});
                    total++;
                end
            end
            if (agu_w > 0) begin
                for (int w = 0; w < agu_w; w++) begin
                    push(sel, 4'b1000);
                    total++;
                end
                for (int h = 0; h < agu_hold; h++) begin
                    push(sel, (h == 0) ? 4'b1010 : 4'b1000);
                    total++;
                end
            end else begin
                for (int w = 0; w < to; w++) begin
                    push(sel, 4'b1000);
                    total++;
                end
                push(sel, (t < tries - 1) ? 4'b0000 : 4'b0001);
                total++;
            end
        end
        @(posedge clk); #1;
        pin = p;
        drive(sel, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'b0);
        for (int c = 1; c <= total + 1; c++) begin
            ag = (agu_w > 0) && (c >= s + agu_w) && (c <= s + agu_w + agu_hold - 1);
            st = 1'b0;
            if (perturb && (c == 2 || c == 3)) begin
                ag = 1'b1;
                st = 1'b1;
            end
            pin = (perturb && c >= 2) ? ~p : p;
            drive(sel, st, ag);
            @(posedge clk); #1;
        end
        drive(sel, 1'b0, 1'b0);
        @(negedge clk);
        cmp({nm, "_leftover"}, 5'((sel == 1) ? q1.size() : q3.size()), 5'd0);
        cmp({nm, "_busy_end"}, {4'b0000, (sel == 1) ? busy1 : busy3}, 5'd0);
        q1.delete();
        q3.delete();
    endtask

    // Global time bound.
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp("reset_dut1", {busy1, a1, b1, g1, d1}, 5'b00000);
        cmp("reset_dut3", {busy3, a3, b3, g3, d3}, 5'b00000);
        #1 rst_n = 1'b1;
        mon_on = 1'b1;

        run_txn("nominal",   1, 5'b10100, BC1, TO1, 3, 4, 1, 1'b0);
        run_txn("pattern2",  1, 5'b01011, BC1, TO1, 1, 1, 1, 1'b0);
        run_txn("stretch",   3, 5'b10100, BC3, TO3, 2, 2, 1, 1'b0);
        run_txn("stretch2",  3, 5'b01101, BC3, TO3, 5, 1, 1, 1'b0);
        run_txn("deny",      1, 5'b11001, BC1, TO1, 0, 0, TRIES, 1'b0);
        run_txn("ignored",   1, 5'b10100, BC1, TO1, 2, 1, 1, 1'b1);
        run_txn("tmo_grant", 1, 5'b00111, BC1, TO1, TO1, 3, 1, 1'b0);

        // Reset on the third SEND cycle, then restart from the MSB.
        q1.push_back(4'b1100);
        q1.push_back(4'b1000);
        q1.push_back(4'b1100);
        @(posedge clk); #1;
        pin = 5'b10100;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        cmp("reset_mid_lines", {busy1, a1, b1, g1, d1}, 5'b00000);
        cmp("reset_mid_queue", 5'(q1.size()), 5'd0);
        q1.delete();
        #1 rst_n = 1'b1;
        run_txn("restart",   1, 5'b11010, BC1, TO1, 2, 2, 1, 1'b0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
